// File: rtl/obi_rsp_pipe_if.sv
// Bus bundle between the core-side response pipe and the downstream OBI port.
// Handshake: req_accept_i is a completed req&&gnt beat; rsp_rvalid_i/core_rvalid_o are single-cycle valid pulses with no ready.
interface obi_rsp_pipe_if #(
  parameter int unsigned DW = 32
);
  logic          req_accept_i;
  logic          rsp_rvalid_i;
  logic [DW-1:0] rsp_rdata_i;
  logic          core_rvalid_o;
  logic [DW-1:0] core_rdata_o;
  logic          req_block_o;

  modport slave (
    input  req_accept_i,
    input  rsp_rvalid_i,
    input  rsp_rdata_i,
    output core_rvalid_o,
    output core_rdata_o,
    output req_block_o
  );

  modport master (
    output req_accept_i,
    output rsp_rvalid_i,
    output rsp_rdata_i,
    input  core_rvalid_o,
    input  core_rdata_o,
    input  req_block_o
  );
endinterface

// File: rtl/obi_rsp_pipe.sv
// OBI response pipe: tracks outstanding requests, drops responses owed to a flushed stream.
// Define OBI_RSP_PROTO_CHK_EN to build the sticky protocol-violation checker.
module obi_rsp_pipe #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned DW        = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_pipeline_i,
  obi_rsp_pipe_if.slave bus,
  output logic [3:0] outst_o,
  output logic       protocol_err_o,
  output logic [1:0] dbg_state_o
);

  localparam logic [3:0] MAX = 4'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    count, count_nxt;
  logic [4:0]    drop, drop_nxt;
  logic          acc, rv, stray, fwd, cnt_inc, cnt_dec;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  assign acc = bus.req_accept_i;
  assign rv  = bus.rsp_rvalid_i;

  // A response is stray only outside FLUSH: there, drop_cnt may exceed count after an over-limit clear.
  assign stray   = rv && (count == 4'd0) && !acc && (state != FLUSH);
  assign cnt_inc = acc && !rv && (count != MAX);
  assign cnt_dec = rv && !acc && (count != 4'd0);
  assign fwd     = rv && !stray && !clear_pipeline_i && (state != FLUSH);

  always_comb begin
    count_nxt = count;
    drop_nxt  = drop;
    state_nxt = state;
    if (cnt_inc) count_nxt = count + 4'd1;
    else if (cnt_dec) count_nxt = count - 4'd1;

    if (clear_pipeline_i) begin
      // Same-cycle accept belongs to the old stream; same-cycle response is consumed by it.
      drop_nxt  = 5'(count) + 5'(acc) - 5'(rv && ((count != 4'd0) || acc));
      state_nxt = (drop_nxt != 5'd0) ? FLUSH : IDLE;
    end else if (state == FLUSH) begin
      if (rv) drop_nxt = drop - 5'd1;
      if (drop_nxt != 5'd0) state_nxt = FLUSH;
      else state_nxt = (count_nxt != 4'd0) ? ACTIVE : IDLE;
    end else begin
      state_nxt = (count_nxt != 4'd0) ? ACTIVE : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= 4'd0;
      drop     <= 5'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      drop     <= drop_nxt;
      rvalid_q <= fwd;
      if (fwd) rdata_q <= bus.rsp_rdata_i;
    end
  end

  assign bus.core_rvalid_o = rvalid_q;
  assign bus.core_rdata_o  = rdata_q;
  assign bus.req_block_o   = (count == MAX);
  assign outst_o           = count;
  assign dbg_state_o       = state;

`ifdef OBI_RSP_PROTO_CHK_EN
  logic overflow;
  logic perr_q;

  assign overflow = acc && !rv && (count == MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perr_q <= 1'b0;
    else if (stray || overflow) perr_q <= 1'b1;
  end

  assign protocol_err_o = perr_q;
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_rsp_pipe.sv
// Self-checking bench for obi_rsp_pipe (MAX_OUTST=2, DW=32): directed scenarios plus a random phase.
module tb_obi_rsp_pipe;
  localparam int MAXO = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clear_pipeline_i = 1'b0;
  logic [3:0] outst_o;
  logic       protocol_err_o;
  logic [1:0] dbg_state_o;

  obi_rsp_pipe_if #(.DW(32)) bus ();

  obi_rsp_pipe #(.MAX_OUTST(MAXO), .DW(32)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_pipeline_i (clear_pipeline_i),
    .bus              (bus),
    .outst_o          (outst_o),
    .protocol_err_o   (protocol_err_o),
    .dbg_state_o      (dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          m_cnt = 0;
  int          m_drop = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_last = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_err();
`ifdef OBI_RSP_PROTO_CHK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_drop > 0) return 2'd2;
    if (m_cnt > 0) return 2'd1;
    return 2'd0;
  endfunction

  // One clock: drive inputs, advance the spec-level model, check outputs #1 after the edge.
  task automatic cyc(input bit acc, input bit rv, input bit clr, input logic [31:0] d);
    bit stray, fwd;
    int nc;
    logic [31:0] e;
    bus.req_accept_i = acc;
    bus.rsp_rvalid_i = rv;
    bus.rsp_rdata_i  = d;
    clear_pipeline_i = clr;
    stray = rv && (m_cnt == 0) && !acc && (m_drop == 0);
    fwd   = rv && !clr && (m_drop == 0) && !stray;
    if (stray || (acc && !rv && m_cnt == MAXO)) m_err = 1'b1;
    nc = m_cnt + int'(acc) - int'(rv);
    if (clr) m_drop = (nc < 0) ? 0 : nc;
    else if (rv && m_drop > 0) m_drop--;
    m_cnt = (nc < 0) ? 0 : (nc > MAXO) ? MAXO : nc;
    if (fwd) exp_q.push_back(d);
    @(posedge clk_i);
    #1;
    bus.req_accept_i = 1'b0;
    bus.rsp_rvalid_i = 1'b0;
    clear_pipeline_i = 1'b0;
    check_val("core_rvalid", 32'(bus.core_rvalid_o), 32'(fwd));
    if (bus.core_rvalid_o) begin
      if (exp_q.size() == 0) check_val("unexpected_rsp", 32'(bus.core_rvalid_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        check_val("core_rdata", bus.core_rdata_o, e);
        m_last = e;
      end
    end else begin
      check_val("rdata_hold", bus.core_rdata_o, m_last);
    end
    check_val("outst", 32'(outst_o), 32'(m_cnt));
    check_val("req_block", 32'(bus.req_block_o), 32'(m_cnt == MAXO));
    check_val("state", 32'(dbg_state_o), 32'(exp_state()));
    check_val("protocol_err", 32'(protocol_err_o), 32'(exp_err()));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_drop = 0; m_err = 1'b0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rvalid"}, 32'(bus.core_rvalid_o), 32'd0);
    check_val({tag, "_rdata"}, bus.core_rdata_o, 32'd0);
    check_val({tag, "_outst"}, 32'(outst_o), 32'd0);
    check_val({tag, "_block"}, 32'(bus.req_block_o), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state_o), 32'd0);
    check_val({tag, "_perr"}, 32'(protocol_err_o), 32'd0);
  endtask

  initial begin
    bus.req_accept_i = 1'b0;
    bus.rsp_rvalid_i = 1'b0;
    bus.rsp_rdata_i  = '0;
    model_reset();
    #23;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single fetch: accept, gap, response forwarded one cycle later.
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'hDEADBEEF);
    check_val("single_outst", 32'(outst_o), 32'd0);

    // Back-to-back to the limit, then simultaneous accept+response holds count.
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    check_val("b2b_block", 32'(bus.req_block_o), 32'd1);
    cyc(1, 1, 0, 32'h11);
    check_val("b2b_outst", 32'(outst_o), 32'd2);

    // Flush with a same-cycle accept: three old-stream responses dropped.
    cyc(1, 0, 1, 32'h0);
    check_val("flush_state", 32'(dbg_state_o), 32'd2);
    cyc(0, 1, 0, 32'h1);
    cyc(0, 1, 0, 32'h2);
    cyc(0, 1, 0, 32'h3);
    check_val("flush_done_state", 32'(dbg_state_o), 32'd0);

    // Post-flush fetch.
    cyc(1, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'hA5A5A5A5);
    check_val("post_flush_state", 32'(dbg_state_o), 32'd0);

    // Response in the clear cycle is dropped; new accept during flush survives.
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(0, 1, 1, 32'h5);
    cyc(1, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h7);
    cyc(0, 1, 0, 32'h8);
    cyc(0, 1, 0, 32'h9);

    // Clear while already flushing reloads drop_cnt.
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0);
    cyc(1, 0, 1, 32'h0);
    cyc(0, 1, 0, 32'h21);
    cyc(0, 1, 0, 32'h22);
    check_val("reclear_state", 32'(dbg_state_o), 32'd0);

    // Stray response with nothing outstanding.
    cyc(0, 1, 0, 32'h33);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 45),
          bit'($urandom_range(0, 99) < 8), $urandom());
    end

    // Reset mid-transaction, then a response after release is a stray.
    cyc(0, 0, 1, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'hCAFE0001);
    cyc(1, 0, 0, 32'h0);
    #3;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cyc(0, 1, 0, 32'hBADBAD00);
    cyc(0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
